// File: rtl/pbs_pkg.sv
// rtl/pbs_pkg.sv - shared types and constants for the PBS battle sequencer
package pbs_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P_LOAD,
    P_ROLL,
    P_APPLY,
    P_CHECK,
    AI_WAIT,
    AI_ROLL,
    AI_APPLY,
    AI_CHECK,
    DONE
  } state_t;

  localparam int HP_W_DEF = 4;
  localparam logic [HP_W_DEF-1:0] HP_MAX = '1;

  localparam logic TR_PLAYER = 1'b0;
  localparam logic TR_AI     = 1'b1;

  typedef enum logic [1:0] {
    MV_0 = 2'd0,
    MV_1 = 2'd1,
    MV_2 = 2'd2,
    MV_3 = 2'd3
  } move_t;

endpackage

// File: rtl/pbs_btn_edge.sv
// rtl/pbs_btn_edge.sv - go button registered copy and rising-edge pulse
module pbs_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic rise
);

  logic go_q;
  logic armed;

  // armed stays low until go has been seen low once, so a button held
  // through reset does not fire on reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      go_q <= go;
      if (!go) armed <= 1'b1;
    end
  end

  assign rise = go & ~go_q & armed;

endmodule

// File: rtl/pbs_ctrl.sv
// rtl/pbs_ctrl.sv - PBS battle-turn sequencer; PBS_MISS_EN enables accuracy misses
module pbs_ctrl
  import pbs_pkg::*;
#(
  parameter int HP_W     = 4,
  parameter int AI_DELAY = 8,
  parameter int TURN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [HP_W-1:0]   p_hp,
  input  logic [HP_W-1:0]   ai_hp,
  input  logic [HP_W-1:0]   accu,
  input  logic [HP_W-1:0]   acc_roll,
  output logic              actr,
  output logic              target,
  output logic              stop,
  output logic              load_ai_hp,
  output logic              app_ai_dmg,
  output logic              app_pl_dmg,
  output logic              miss,
  output logic              busy,
  output logic              game_over,
  output logic              winner,
  output logic [TURN_W-1:0] turn_cnt
);

  localparam int CNT_W = (AI_DELAY > 1) ? $clog2(AI_DELAY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(AI_DELAY - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             rise;
  logic             roll_hit;

  pbs_btn_edge u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .rise (rise)
  );

`ifdef PBS_MISS_EN
  assign roll_hit = (acc_roll <= accu);
`else
  logic unused_roll;
  assign roll_hit    = 1'b1;
  assign unused_roll = ^{acc_roll, accu};
`endif

  // Strobes are set on entry to the state they belong to, so each is high
  // for exactly the one cycle spent in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      actr       <= TR_PLAYER;
      target     <= 1'b1;
      stop       <= 1'b0;
      load_ai_hp <= 1'b0;
      app_ai_dmg <= 1'b0;
      app_pl_dmg <= 1'b0;
      miss       <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      turn_cnt   <= '0;
    end else begin
      stop       <= 1'b0;
      load_ai_hp <= 1'b0;
      app_ai_dmg <= 1'b0;
      app_pl_dmg <= 1'b0;
      miss       <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= P_LOAD;
            load_ai_hp <= 1'b1;
            busy       <= 1'b1;
            actr       <= TR_PLAYER;
            target     <= ~TR_PLAYER;
          end
        end
        P_LOAD: begin
          state <= P_ROLL;
          stop  <= 1'b1;
        end
        P_ROLL: begin
          state      <= P_APPLY;
          app_ai_dmg <= roll_hit;
          miss       <= ~roll_hit;
        end
        P_APPLY: begin
          state <= P_CHECK;
        end
        P_CHECK: begin
          if (ai_hp == '0) begin
            state     <= DONE;
            game_over <= 1'b1;
            winner    <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state    <= AI_WAIT;
            wait_cnt <= WAIT_LOAD;
            actr     <= TR_AI;
            target   <= ~TR_AI;
          end
        end
        AI_WAIT: begin
          if (wait_cnt == '0) begin
            state <= AI_ROLL;
            stop  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        AI_ROLL: begin
          state      <= AI_APPLY;
          app_pl_dmg <= roll_hit;
          miss       <= ~roll_hit;
        end
        AI_APPLY: begin
          state <= AI_CHECK;
        end
        AI_CHECK: begin
          busy   <= 1'b0;
          actr   <= TR_PLAYER;
          target <= ~TR_PLAYER;
          if (p_hp == '0) begin
            state     <= DONE;
            game_over <= 1'b1;
            winner    <= 1'b0;
          end else begin
            state <= IDLE;
            if (turn_cnt != '1) turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbs_ctrl.sv
// tb/tb_pbs_ctrl.sv - directed self-checking bench for pbs_ctrl
module tb_pbs_ctrl;

  localparam int HP_W     = 4;
  localparam int AI_DELAY = 8;
  localparam int TURN_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [HP_W-1:0]   p_hp;
  logic [HP_W-1:0]   ai_hp;
  logic [HP_W-1:0]   accu;
  logic [HP_W-1:0]   acc_roll;
  logic              actr;
  logic              target;
  logic              stop;
  logic              load_ai_hp;
  logic              app_ai_dmg;
  logic              app_pl_dmg;
  logic              miss;
  logic              busy;
  logic              game_over;
  logic              winner;
  logic [TURN_W-1:0] turn_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pbs_ctrl #(
    .HP_W     (HP_W),
    .AI_DELAY (AI_DELAY),
    .TURN_W   (TURN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .p_hp       (p_hp),
    .ai_hp      (ai_hp),
    .accu       (accu),
    .acc_roll   (acc_roll),
    .actr       (actr),
    .target     (target),
    .stop       (stop),
    .load_ai_hp (load_ai_hp),
    .app_ai_dmg (app_ai_dmg),
    .app_pl_dmg (app_pl_dmg),
    .miss       (miss),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner),
    .turn_cnt   (turn_cnt)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    go  = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    go = 1'b1; p_hp = 4'd15; ai_hp = 4'd15; accu = 4'd15; acc_roll = 4'd0;
    rst = 1'b0;
    step(2);
    checks++; if (busy !== 1'b0 || game_over !== 1'b0 || winner !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b game_over=%b winner=%b expected 0 0 0", busy, game_over, winner); end
    checks++; if (turn_cnt !== 8'd0) begin errors++; $display("FAIL reset_turn_cnt: got %0d expected 0", turn_cnt); end
    checks++; if (actr !== 1'b0 || target !== 1'b1) begin errors++; $display("FAIL reset_actr_target: actr=%b target=%b expected 0 1", actr, target); end
    checks++; if ({stop, load_ai_hp, app_ai_dmg, app_pl_dmg, miss} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {stop, load_ai_hp, app_ai_dmg, app_pl_dmg, miss}); end
    rst = 1'b1;
    step(3);
    checks++; if (busy !== 1'b0 || load_ai_hp !== 1'b0) begin errors++; $display("FAIL reset_held_go: busy=%b load_ai_hp=%b expected 0 0", busy, load_ai_hp); end
    go = 1'b0; step(1);
    go = 1'b1; step(1);
    checks++; if (load_ai_hp !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL reset_rego: load_ai_hp=%b busy=%b expected 1 1", load_ai_hp, busy); end
    do_reset();
  endtask

  task automatic test_full_round;
    int wait_seen;
    do_reset();
    p_hp = 4'd15; ai_hp = 4'd15; accu = 4'd15; acc_roll = 4'd0;
    go = 1'b1; step(1);
    checks++; if (load_ai_hp !== 1'b1 || stop !== 1'b0) begin errors++; $display("FAIL round_load: load_ai_hp=%b stop=%b expected 1 0", load_ai_hp, stop); end
    go = 1'b0; step(1);
    checks++; if (stop !== 1'b1 || load_ai_hp !== 1'b0) begin errors++; $display("FAIL round_stop: stop=%b load_ai_hp=%b expected 1 0", stop, load_ai_hp); end
    step(1);
    checks++; if (app_ai_dmg !== 1'b1 || miss !== 1'b0 || app_pl_dmg !== 1'b0) begin errors++; $display("FAIL round_ai_dmg: app_ai_dmg=%b miss=%b app_pl_dmg=%b expected 1 0 0", app_ai_dmg, miss, app_pl_dmg); end
    ai_hp = ai_hp - 4'd1;
    step(1);
    checks++; if (app_ai_dmg !== 1'b0 || busy !== 1'b1 || actr !== 1'b0 || target !== 1'b1) begin errors++; $display("FAIL round_p_check: app_ai_dmg=%b busy=%b actr=%b target=%b expected 0 1 0 1", app_ai_dmg, busy, actr, target); end
    wait_seen = 0;
    for (int i = 0; i < AI_DELAY; i++) begin
      step(1);
      if (actr === 1'b1 && target === 1'b0 && stop === 1'b0 && app_pl_dmg === 1'b0) wait_seen++;
    end
    checks++; if (wait_seen !== AI_DELAY) begin errors++; $display("FAIL round_ai_wait: quiet AI cycles=%0d expected %0d", wait_seen, AI_DELAY); end
    step(1);
    checks++; if (stop !== 1'b1 || actr !== 1'b1) begin errors++; $display("FAIL round_ai_stop: stop=%b actr=%b expected 1 1", stop, actr); end
    step(1);
    checks++; if (app_pl_dmg !== 1'b1 || app_ai_dmg !== 1'b0) begin errors++; $display("FAIL round_pl_dmg: app_pl_dmg=%b app_ai_dmg=%b expected 1 0", app_pl_dmg, app_ai_dmg); end
    p_hp = p_hp - 4'd1;
    step(1);
    checks++; if (turn_cnt !== 8'd0 || busy !== 1'b1 || app_pl_dmg !== 1'b0) begin errors++; $display("FAIL round_ai_check: turn_cnt=%0d busy=%b app_pl_dmg=%b expected 0 1 0", turn_cnt, busy, app_pl_dmg); end
    step(1);
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd1 || actr !== 1'b0 || target !== 1'b1 || game_over !== 1'b0) begin errors++; $display("FAIL round_idle: busy=%b turn_cnt=%0d actr=%b target=%b game_over=%b expected 0 1 0 1 0", busy, turn_cnt, actr, target, game_over); end
  endtask

  task automatic test_miss;
    accu = 4'd3; acc_roll = 4'd9;
    go = 1'b1; step(1);
    go = 1'b0; step(2);
`ifdef PBS_MISS_EN
    checks++; if (app_ai_dmg !== 1'b0 || miss !== 1'b1) begin errors++; $display("FAIL miss_player: app_ai_dmg=%b miss=%b expected 0 1", app_ai_dmg, miss); end
`else
    checks++; if (app_ai_dmg !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL miss_forced_hit: app_ai_dmg=%b miss=%b expected 1 0", app_ai_dmg, miss); end
    ai_hp = ai_hp - 4'd1;
`endif
    step(1);
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL miss_width: miss=%b expected 0", miss); end
    step(AI_DELAY + 2);
`ifdef PBS_MISS_EN
    checks++; if (app_pl_dmg !== 1'b0 || miss !== 1'b1) begin errors++; $display("FAIL miss_ai: app_pl_dmg=%b miss=%b expected 0 1", app_pl_dmg, miss); end
`else
    checks++; if (app_pl_dmg !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL miss_ai_forced: app_pl_dmg=%b miss=%b expected 1 0", app_pl_dmg, miss); end
    p_hp = p_hp - 4'd1;
`endif
    step(2);
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd2) begin errors++; $display("FAIL miss_idle: busy=%b turn_cnt=%0d expected 0 2", busy, turn_cnt); end
    acc_roll = 4'd3;
    go = 1'b1; step(1);
    go = 1'b0; step(2);
    checks++; if (app_ai_dmg !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL miss_equal_hits: app_ai_dmg=%b miss=%b expected 1 0", app_ai_dmg, miss); end
    ai_hp = ai_hp - 4'd1;
    step(AI_DELAY + 3);
    p_hp = p_hp - 4'd1;
    step(2);
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd3) begin errors++; $display("FAIL miss_idle2: busy=%b turn_cnt=%0d expected 0 3", busy, turn_cnt); end
  endtask

  task automatic test_player_win;
    int stray;
    do_reset();
    p_hp = 4'd15; ai_hp = 4'd2; accu = 4'd15; acc_roll = 4'd0;
    go = 1'b1; step(1);
    go = 1'b0; step(2);
    checks++; if (app_ai_dmg !== 1'b1) begin errors++; $display("FAIL pwin_dmg: app_ai_dmg=%b expected 1", app_ai_dmg); end
    ai_hp = 4'd0;
    step(2);
    checks++; if (game_over !== 1'b1 || winner !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pwin_done: game_over=%b winner=%b busy=%b expected 1 1 0", game_over, winner, busy); end
    stray = 0;
    for (int i = 0; i < 16; i++) begin
      go = ((i % 4) >= 2);
      step(1);
      if (stop || load_ai_hp || app_ai_dmg || app_pl_dmg || actr || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL pwin_quiet: active cycles in DONE=%0d expected 0", stray); end
    checks++; if (game_over !== 1'b1 || winner !== 1'b1) begin errors++; $display("FAIL pwin_sticky: game_over=%b winner=%b expected 1 1", game_over, winner); end
  endtask

  task automatic test_dead_ai;
    do_reset();
    p_hp = 4'd15; ai_hp = 4'd0; accu = 4'd15; acc_roll = 4'd15;
    go = 1'b1; step(1);
    go = 1'b0; step(2);
    checks++; if (app_ai_dmg !== 1'b1) begin errors++; $display("FAIL dead_ai_dmg: app_ai_dmg=%b expected 1", app_ai_dmg); end
    step(2);
    checks++; if (game_over !== 1'b1 || winner !== 1'b1 || actr !== 1'b0) begin errors++; $display("FAIL dead_ai_done: game_over=%b winner=%b actr=%b expected 1 1 0", game_over, winner, actr); end
  endtask

  task automatic test_ai_win;
    do_reset();
    p_hp = 4'd1; ai_hp = 4'd15; accu = 4'd15; acc_roll = 4'd0;
    go = 1'b1; step(1);
    go = 1'b0; step(2);
    ai_hp = ai_hp - 4'd1;
    step(AI_DELAY + 3);
    checks++; if (app_pl_dmg !== 1'b1) begin errors++; $display("FAIL aiwin_dmg: app_pl_dmg=%b expected 1", app_pl_dmg); end
    p_hp = 4'd0;
    step(2);
    checks++; if (game_over !== 1'b1 || winner !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL aiwin_done: game_over=%b winner=%b busy=%b expected 1 0 0", game_over, winner, busy); end
    checks++; if (turn_cnt !== 8'd0) begin errors++; $display("FAIL aiwin_turn_cnt: got %0d expected 0", turn_cnt); end
  endtask

  task automatic test_reset_mid;
    int stray;
    do_reset();
    p_hp = 4'd15; ai_hp = 4'd15; accu = 4'd15; acc_roll = 4'd0;
    go = 1'b1; step(1);
    go = 1'b0; step(6);
    checks++; if (actr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmid_in_wait: actr=%b busy=%b expected 1 1", actr, busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || actr !== 1'b0 || target !== 1'b1) begin errors++; $display("FAIL rmid_async: busy=%b actr=%b target=%b expected 0 0 1", busy, actr, target); end
    step(2);
    rst = 1'b1;
    p_hp = 4'd0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (app_pl_dmg || stop || busy || game_over) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_quiet: active cycles after abort=%0d expected 0", stray); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    p_hp = 4'd15; ai_hp = 4'd15; accu = 4'd15; acc_roll = 4'd0;
    go = 1'b1; step(1);
    checks++; if (load_ai_hp !== 1'b1) begin errors++; $display("FAIL b2b_first: load_ai_hp=%b expected 1", load_ai_hp); end
    go = 1'b0; step(1);
    go = 1'b1; step(1);
    ai_hp = ai_hp - 4'd1;
    step(AI_DELAY + 5);
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd1 || load_ai_hp !== 1'b0) begin errors++; $display("FAIL b2b_round1: busy=%b turn_cnt=%0d load_ai_hp=%b expected 0 1 0", busy, turn_cnt, load_ai_hp); end
    step(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_not_queued: busy=%b expected 0", busy); end
    go = 1'b0; step(1);
    go = 1'b1; step(1);
    checks++; if (load_ai_hp !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_second: load_ai_hp=%b busy=%b expected 1 1", load_ai_hp, busy); end
    go = 1'b0;
    step(AI_DELAY + 7);
    checks++; if (busy !== 1'b0 || turn_cnt !== 8'd2) begin errors++; $display("FAIL b2b_round2: busy=%b turn_cnt=%0d expected 0 2", busy, turn_cnt); end
  endtask

  initial begin
    rst = 1'b0; go = 1'b0;
    p_hp = '0; ai_hp = '0; accu = '0; acc_roll = '0;
    test_reset();
    test_full_round();
    test_miss();
    test_player_win();
    test_dead_ai();
    test_ai_win();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
